// File: rtl/regfile_wb.sv
// Integer register file at the MEM/WB boundary: two combinational read ports plus a load-use pending scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-through and bypass masking of the pending flags.
module regfile_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              mark_pend,
  input  logic [ADDR_W-1:0] mark_addr,
  input  logic              flush,
  output logic              pend1,
  output logic              pend2
);

  logic [DATA_W-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_pend;
  logic [REG_NUM-1:0] w_pend_nxt;
  logic               w_wr_ok;
  logic               w_byp1;
  logic               w_byp2;
  logic               w_bclr1;
  logic               w_bclr2;

  assign w_wr_ok = we && (waddr != '0);

`ifdef REGFILE_BYPASS_EN
  assign w_byp1  = w_wr_ok && (waddr == raddr1);
  assign w_byp2  = w_wr_ok && (waddr == raddr2);
  assign w_bclr1 = we && (waddr == raddr1);
  assign w_bclr2 = we && (waddr == raddr2);
`else
  assign w_byp1  = 1'b0;
  assign w_byp2  = 1'b0;
  assign w_bclr1 = 1'b0;
  assign w_bclr2 = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic              i_rst,
    input logic              i_re,
    input logic [ADDR_W-1:0] i_ra,
    input logic              i_byp,
    input logic [DATA_W-1:0] i_wd,
    input logic [DATA_W-1:0] i_stored
  );
    if (i_rst || !i_re || (i_ra == '0)) return '0;
    else if (i_byp)                       return i_wd;
    else                                  return i_stored;
  endfunction

  function automatic logic pend_sel(
    input logic              i_rst,
    input logic              i_re,
    input logic [ADDR_W-1:0] i_ra,
    input logic              i_bclr,
    input logic              i_pbit
  );
    return !i_rst && i_re && (i_ra != '0) && i_pbit && !i_bclr;
  endfunction

  // Clear from a retiring write first, then set from a newly issued load so the set wins on a tie.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok) w_pend_nxt[waddr] = 1'b0;
    if (mark_pend && (mark_addr != '0)) w_pend_nxt[mark_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_ok) r_regs[waddr] <= wdata;
      // A flush squashes any load issued in the same cycle.
      if (flush) r_pend <= '0;
      else       r_pend <= w_pend_nxt;
    end
  end

  assign rdata1 = rd_sel(rst, re1, raddr1, w_byp1, wdata, r_regs[raddr1]);
  assign rdata2 = rd_sel(rst, re2, raddr2, w_byp2, wdata, r_regs[raddr2]);
  assign pend1  = pend_sel(rst, re1, raddr1, w_bclr1, r_pend[raddr1]);
  assign pend2  = pend_sel(rst, re2, raddr2, w_bclr2, r_pend[raddr2]);

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural integer register file at the consuming end of the MEM/WB pipeline register.
- Accepts the writeback triple (rd, wdata, wreg) once per cycle.
- Serves two combinational read ports to the ID stage.
- Keeps a per-register pending-load scoreboard so ID can detect load-use hazards and raise stall requests.

Parameters:
- DATA_W, 32, register width (matches RegBus).
- ADDR_W, 5, register index width (matches RegAddrBus).
- REG_NUM, 32, number of architectural registers; index 0 is hardwired zero.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high (RstEnable = 1).
- we  in  1  write enable from MEM/WB (wb_wreg).
- waddr  in  ADDR_W  write register index (wb_rd).
- wdata  in  DATA_W  write data (wb_wdata).
- re1  in  1  read enable, port 1.
- raddr1  in  ADDR_W  read index, port 1.
- rdata1  out  DATA_W  read data, port 1.
- re2  in  1  read enable, port 2.
- raddr2  in  ADDR_W  read index, port 2.
- rdata2  out  DATA_W  read data, port 2.
- mark_pend  in  1  ID is issuing a load that will write mark_addr.
- mark_addr  in  ADDR_W  destination of the issued load.
- flush  in  1  pipeline flush; clears the whole scoreboard.
- pend1  out  1  raddr1 has an outstanding load write.
- pend2  out  1  raddr2 has an outstanding load write.

Behaviour:
- Storage: REG_NUM x DATA_W array plus REG_NUM-bit pend vector, both synchronous.
- Reset (rst=1 at posedge): all registers := 0, all pend bits := 0.
- While rst=1, rdata1, rdata2, pend1 and pend2 are forced to 0 combinationally.
- Write: at posedge, if we=1 and waddr!=0, then reg[waddr] := wdata. Writes to x0 are dropped silently.
- Read, combinational, zero latency, evaluated in priority order for each port n:
  - rst=1 -> 0.
  - ren=0 -> 0.
  - raddrn=0 -> 0.
  - bypass hit (we=1 and waddr==raddrn and waddr!=0) -> wdata, i.e. same-cycle write-through.
  - otherwise -> reg[raddrn].
- Both ports may read the same index, and both may hit the bypass in the same cycle.
- Scoreboard, at posedge, in priority order:
  - rst=1 -> all pend := 0.
  - flush=1 -> all pend := 0. Any same-cycle mark_pend is ignored, because the load is squashed.
  - Otherwise the clear is applied first: if we=1 and waddr!=0, pend[waddr] := 0.
  - Then the set is applied: if mark_pend=1 and mark_addr!=0, pend[mark_addr] := 1.
  - If the clear and the set hit the same index in the same cycle, the set wins and the bit ends at 1 (a new load was issued behind a retiring write).
- pend outputs, combinational:
  - pendn = ren and (raddrn!=0) and pend[raddrn] and not bypass-clear.
  - bypass-clear = we=1 and waddr==raddrn, so a load retiring this cycle is not reported as pending.
  - pend[0] is never set.
- A write to a register whose pend bit is 0 is legal (ALU results) and has no scoreboard effect.
- No stall input: the block never holds state. Callers stall by deasserting we and mark_pend.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: same-cycle write-through bypass exists on both read ports, and pendn is masked by bypass-clear, exactly as described above.
- Undefined: reads return only stored reg[raddrn]; a same-cycle write becomes visible the next cycle. pendn = ren and (raddrn!=0) and pend[raddrn], with no bypass masking. ID must then treat a WB-stage rd match as a one-cycle hazard.

Test Plan:
- Reset then read: rst=1 for 2 cycles, release; re1=1, raddr1=5 -> rdata1=0, pend1=0.
- Write then read: we=1, waddr=3, wdata=0xDEADBEEF at cycle N. With re1=1, raddr1=3:
  - cycle N+1 -> rdata1=0xDEADBEEF.
  - cycle N, with bypass enabled -> 0xDEADBEEF.
  - cycle N, with bypass disabled -> previous value.
- x0 protection: we=1, waddr=0, wdata=0xFFFFFFFF; re1=re2=1, raddr1=raddr2=0 -> both rdata=0 during and after the write.
- Load-use scoreboard:
  - mark_pend=1, mark_addr=7 at cycle N -> pend1=1 for raddr1=7 from N+1.
  - we=1, waddr=7, wdata=0x42 at cycle N+3 -> pend1=0 in N+3 with bypass (N+4 without).
  - rdata1=0x42.
- Simultaneous set/clear: pend[9]=1; in one cycle we=1, waddr=9 and mark_pend=1, mark_addr=9 -> pend[9]=1 next cycle, reg[9] updated.
- Flush and reset mid-operation:
  - pend[4]=pend[12]=1; flush=1 with mark_pend=1, mark_addr=20 -> all pend=0 next cycle, pend[20]=0.
  - Repeat with rst=1 instead -> registers 4 and 12 also read 0.
